// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcode/funct values,
// controller state encoding, datapath mux encodings and instruction-class decode.
package mips_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // Controller states; the numeric values are visible on the debug port
    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM      = 3'd3,
        S_WB       = 3'd4,
        S_MDU_WAIT = 3'd5
    } state_e;

    // Next-PC source
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    // Register file write address source
    localparam logic [1:0] ASEL_RT = 2'd0;
    localparam logic [1:0] ASEL_RD = 2'd1;
    localparam logic [1:0] ASEL_RA = 2'd2;

    // Register file write data source
    localparam logic [1:0] DSEL_ALU  = 2'd0;
    localparam logic [1:0] DSEL_DM   = 2'd1;
    localparam logic [1:0] DSEL_PC4  = 2'd2;
    localparam logic [1:0] DSEL_HILO = 2'd3;

    // Immediate extension
    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    // ALU operation
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;

    // Width of the MDU busy down-counter (holds DIV_CYC comfortably)
    localparam int MDU_CNT_W = 8;

    // Instruction classes: instructions that sequence identically share a class
    typedef enum logic [3:0] {
        I_NOP, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ,
        I_J, I_JAL, I_JR, I_MULT, I_DIV, I_MFHL, I_MTHL
    } instr_e;

    // Map op/funct onto a class; anything unrecognised (and sll) behaves as nop
    function automatic instr_e decode_instr(input logic [5:0] op, input logic [5:0] funct);
        instr_e c;
        c = I_NOP;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU:             c = I_ADDU;
                    FN_SUBU:             c = I_SUBU;
                    FN_JR:               c = I_JR;
                    FN_MULT, FN_MULTU:   c = I_MULT;
                    FN_DIV, FN_DIVU:     c = I_DIV;
                    FN_MFHI, FN_MFLO:    c = I_MFHL;
                    FN_MTHI, FN_MTLO:    c = I_MTHL;
                    default:             c = I_NOP;
                endcase
            end
            OP_J:    c = I_J;
            OP_JAL:  c = I_JAL;
            OP_BEQ:  c = I_BEQ;
            OP_ORI:  c = I_ORI;
            OP_LUI:  c = I_LUI;
            OP_LW:   c = I_LW;
            OP_SW:   c = I_SW;
            default: c = I_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_mdu_timer.sv
// Busy down-counter for the multiply/divide unit. A load pulse sets the
// number of busy cycles; busy stays high until the count drains to zero.
module mc_mdu_timer
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [MDU_CNT_W-1:0] load_val,
    output logic                 busy
);

    logic [MDU_CNT_W-1:0] count;

    // Load on start, otherwise count down one per cycle until empty
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: steps one instruction at a time through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath mux selects and write enables.
// Optional multiply/divide sequencing is enabled by defining MC_CTRL_MDU_EN;
// without it the MDU opcodes behave as nop and mdu_start/busy stay 0.
module mc_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       ir_we,
    output logic       grf_we,
    output logic [1:0] grf_asel,
    output logic [1:0] grf_dsel,
    output logic       alu_srcb,
    output logic [1:0] ext_op,
    output logic [2:0] alu_op,
    output logic       dm_we,
    output logic       mdu_start,
    output logic       busy,
    output logic [2:0] state
);

    state_e cur_state;
    state_e nxt_state;
    instr_e cls;
    logic   mdu_busy;

    // Classify the instruction in IR; MDU classes collapse to nop when the unit is absent
    always_comb begin
        cls = decode_instr(op, funct);
`ifndef MC_CTRL_MDU_EN
        if (cls inside {I_MULT, I_DIV, I_MFHL, I_MTHL}) begin
            cls = I_NOP;
        end
`endif
    end

`ifdef MC_CTRL_MDU_EN
    logic [MDU_CNT_W-1:0] mdu_load_val;

    assign mdu_load_val = (cls == I_DIV) ? MDU_CNT_W'(DIV_CYC) : MDU_CNT_W'(MULT_CYC);

    mc_mdu_timer u_mdu_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (mdu_start),
        .load_val (mdu_load_val),
        .busy     (mdu_busy)
    );
`else
    logic unused_cfg;

    assign unused_cfg = (MULT_CYC != 0) ^ (DIV_CYC != 0);
    assign mdu_busy   = 1'b0;
`endif

    // State register; reset returns to FETCH, abandoning any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state selection from the current state and instruction class
    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH: nxt_state = S_DECODE;
            S_DECODE: begin
                case (cls)
                    I_J, I_JAL, I_JR, I_NOP:      nxt_state = S_FETCH;
                    I_MULT, I_DIV, I_MFHL, I_MTHL: nxt_state = mdu_busy ? S_MDU_WAIT : S_EXEC;
                    default:                      nxt_state = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls)
                    I_ADDU, I_SUBU, I_ORI, I_LUI, I_MFHL: nxt_state = S_WB;
                    I_LW, I_SW:                          nxt_state = S_MEM;
                    default:                             nxt_state = S_FETCH;
                endcase
            end
            S_MEM:      nxt_state = (cls == I_LW) ? S_WB : S_FETCH;
            S_WB:       nxt_state = S_FETCH;
            S_MDU_WAIT: nxt_state = mdu_busy ? S_MDU_WAIT : S_EXEC;
            default:    nxt_state = S_FETCH;
        endcase
    end

    // Datapath controls; ALU/ext settings persist from EXEC through WB, writes are masked in reset
    always_comb begin
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        ir_we     = 1'b0;
        grf_we    = 1'b0;
        grf_asel  = ASEL_RT;
        grf_dsel  = DSEL_ALU;
        alu_srcb  = 1'b0;
        ext_op    = EXT_ZERO;
        alu_op    = ALU_ADD;
        dm_we     = 1'b0;
        mdu_start = 1'b0;
        case (cur_state)
            S_FETCH: begin
                ir_we  = 1'b1;
                pc_we  = 1'b1;
                pc_sel = PC_PLUS4;
            end
            S_DECODE: begin
                case (cls)
                    I_J: begin
                        pc_we  = 1'b1;
                        pc_sel = PC_JUMP;
                    end
                    I_JAL: begin
                        pc_we    = 1'b1;
                        pc_sel   = PC_JUMP;
                        grf_we   = 1'b1;
                        grf_asel = ASEL_RA;
                        grf_dsel = DSEL_PC4;
                    end
                    I_JR: begin
                        pc_we  = 1'b1;
                        pc_sel = PC_REG;
                    end
                    default: ;
                endcase
            end
            S_EXEC, S_MEM, S_WB: begin
                case (cls)
                    I_SUBU, I_BEQ: alu_op = ALU_SUB;
                    I_ORI: begin
                        alu_op   = ALU_OR;
                        alu_srcb = 1'b1;
                        ext_op   = EXT_ZERO;
                    end
                    I_LUI: begin
                        alu_op   = ALU_OR;
                        alu_srcb = 1'b1;
                        ext_op   = EXT_LUI;
                    end
                    I_LW, I_SW: begin
                        alu_op   = ALU_ADD;
                        alu_srcb = 1'b1;
                        ext_op   = EXT_SIGN;
                    end
                    default: ;
                endcase
                if (cur_state == S_EXEC) begin
                    if (cls == I_BEQ) begin
                        pc_we  = zero;
                        pc_sel = PC_BRANCH;
                    end
                    if (cls == I_MULT || cls == I_DIV) begin
                        mdu_start = 1'b1;
                    end
                end
                if (cur_state == S_MEM && cls == I_SW) begin
                    dm_we = 1'b1;
                end
                if (cur_state == S_WB) begin
                    case (cls)
                        I_ADDU, I_SUBU: begin
                            grf_we   = 1'b1;
                            grf_asel = ASEL_RD;
                            grf_dsel = DSEL_ALU;
                        end
                        I_ORI, I_LUI: begin
                            grf_we   = 1'b1;
                            grf_asel = ASEL_RT;
                            grf_dsel = DSEL_ALU;
                        end
                        I_LW: begin
                            grf_we   = 1'b1;
                            grf_asel = ASEL_RT;
                            grf_dsel = DSEL_DM;
                        end
                        I_MFHL: begin
                            grf_we   = 1'b1;
                            grf_asel = ASEL_RD;
                            grf_dsel = DSEL_HILO;
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
        if (reset) begin
            pc_we     = 1'b0;
            ir_we     = 1'b0;
            grf_we    = 1'b0;
            dm_we     = 1'b0;
            mdu_start = 1'b0;
        end
    end

    assign busy  = mdu_busy & ~reset;
    assign state = cur_state;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS core. It sequences the fetch unit, register file, ALU and data memory through a FETCH/DECODE/EXEC/MEM/WB state machine, one instruction at a time, so that IM, ALU and DM are each used at most once per step. It sits between the instruction register, whose op/funct fields feed it, and the datapath muxes and write enables it drives.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles for mult/multu (MDU build only)
- DIV_CYC, 10, busy cycles for div/divu (MDU build only)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU equality flag (rs==rt)
- pc_we  out  1  PC write enable
- pc_sel  out  2  0 PC+4, 1 branch target, 2 jump imm26, 3 GRF[rs]
- ir_we  out  1  instruction register write enable
- grf_we  out  1  register file write enable
- grf_asel  out  2  write address: 0 rt, 1 rd, 2 $31
- grf_dsel  out  2  write data: 0 ALU, 1 DM, 2 PC+4, 3 HI/LO
- alu_srcb  out  1  0 GRF[rt], 1 extended imm
- ext_op  out  2  0 zero-ext, 1 sign-ext, 2 imm<<16
- alu_op  out  3  0 add, 1 sub, 2 or
- dm_we  out  1  data memory write enable
- mdu_start  out  1  one-cycle MDU start pulse (tied 0 without MDU)
- busy  out  1  MDU busy (tied 0 without MDU)
- state  out  3  current state, debug/verification

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDU_WAIT=5.
- FETCH: ir_we=1, pc_we=1, pc_sel=0; -> DECODE.
- DECODE: j: pc_we=1, pc_sel=2 -> FETCH. jal: additionally grf_we=1, asel=2, dsel=2. jr: pc_we=1, pc_sel=3 -> FETCH. Undefined op/funct and sll (nop): no writes -> FETCH. Others -> EXEC.
- EXEC: addu/subu/ori/lui -> WB. lw/sw: alu_op=add, srcb=1, ext_op=1 -> MEM. beq: alu_op=sub, pc_we=zero, pc_sel=1 -> FETCH.
- MEM: sw: dm_we=1 -> FETCH; lw -> WB.
- WB: grf_we=1; R-type asel=1 dsel=0; ori/lui asel=0 dsel=0; lw asel=0 dsel=1 -> FETCH.
- ALU/ext controls are held stable from EXEC through WB for the active instruction.
- Outputs are combinational from state and op/funct; IR is stable outside FETCH.
- Every output not listed for a state is 0.

## Timing
- CPI: j/jr/jal/nop 2; beq 3; R-type, ori, lui, sw 4; lw 5.
- PC+4 used by jal and branch target is the value latched in FETCH.
- Reset: state=FETCH at the next edge; while reset is high all write enables (pc_we, ir_we, grf_we, dm_we, mdu_start) are forced 0; busy=0, counter=0. Reset mid-instruction aborts it with no further writes.
- No writes occur in any cycle other than those listed above.

## Configuration
- Macro MC_CTRL_MDU_EN.
- Defined: mult/multu/div/divu in EXEC pulse mdu_start, load counter with MULT_CYC or DIV_CYC, -> FETCH; busy=1 while counter>0, decrementing each cycle. mfhi/mflo/mthi/mtlo in DECODE while busy -> MDU_WAIT, hold there until counter reaches 0, then -> EXEC; mfhi/mflo write back in WB with dsel=3, asel=1. A new mult/div while busy also waits in MDU_WAIT.
- Undefined: MDU opcodes decode as nop; MDU_WAIT unreachable; mdu_start=busy=0.

## Structure
- Shared package mips_pkg: opcode/funct localparams, state encodings, pc_sel/asel/dsel/alu_op/ext_op encodings.
- Optional sub-module mc_mdu_timer: busy down-counter with load/start.

## Test plan
- Reset held 2 cycles mid-lw EXEC -> state=0, dm_we=grf_we=0, then FETCH with pc_we=1.
- addu $3,$1,$2 -> states 0,1,2,4; WB grf_we=1, asel=1, dsel=0; 4 cycles.
- lw $5,8($0) -> 0,1,2,3,4; WB dsel=1, asel=0; sw -> dm_we=1 only in MEM.
- beq with zero=1 -> EXEC pc_we=1, pc_sel=1; zero=0 -> pc_we=0; both 3 cycles.
- jal 0x0C00 -> DECODE pc_sel=2, grf_we=1, asel=2, dsel=2; 2 cycles.
- MDU build: mult then mflo immediately -> mflo waits in MDU_WAIT until 5 busy cycles expire, then WB dsel=3.
